sr_mul_seq: RTL
===============

SR_MUL_SEQ -- requirements
Module: sr_mul_seq

Interface
REQ-001 The module SHALL have one parameter: WIDTH, default 32, operand and result width in bits.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The module SHALL have port start, input, 1 bit: multiply request, sampled on a clk edge.
REQ-005 The module SHALL have port srcA, input, WIDTH bits: multiplicand, sampled with start.
REQ-006 The module SHALL have port srcB, input, WIDTH bits: multiplier, sampled with start.
REQ-007 The module SHALL have port busy, output, 1 bit: high while an operation iterates; the CPU stalls on it.
REQ-008 The module SHALL have port done, output, 1 bit: single-cycle pulse marking result valid.
REQ-009 The module SHALL have port result, output, WIDTH bits: low WIDTH bits of srcA*srcB (RV32 MUL semantics).

Function
REQ-010 The block SHALL be a radix-2 shift-add sequencer with FSM states IDLE, RUN and DONE.
REQ-011 Internal registers SHALL be: acc (WIDTH), mcand (WIDTH), mplier (WIDTH), cnt (ceil(log2(WIDTH)) bits).
REQ-012 In IDLE or DONE with start=1 at an edge, the block SHALL load mcand=srcA, mplier=srcB, acc=0, cnt=0, and go to RUN.
REQ-013 IDLE with start=0 SHALL remain in IDLE; DONE with start=0 SHALL go to IDLE.
REQ-014 Each RUN edge SHALL perform one step: acc += mcand if mplier[0]=1 (mod 2^WIDTH); mcand <<= 1; mplier >>= 1; cnt += 1.
REQ-015 RUN SHALL go to DONE on the edge where the shifted mplier equals 0 or cnt equals WIDTH-1 (early termination); otherwise it stays in RUN.
REQ-016 On the RUN-to-DONE edge, result SHALL be loaded with the final acc value, including that edge's step.
REQ-017 result SHALL change only on the RUN-to-DONE edge and on reset; it holds between operations.
REQ-018 Timing: with start high in cycle 0, RUN SHALL occupy cycles 1..n, where n = max(1, 1 + index of highest set bit of srcB), and done SHALL be high in cycle n+1 only.
REQ-019 Latency from start to done SHALL be min 2 cycles and max WIDTH+1 cycles.
REQ-020 busy SHALL equal (state==RUN); done SHALL equal (state==DONE); both outputs are registered-state decodes with no combinational path from inputs.
REQ-021 start while in RUN SHALL be ignored; srcA and srcB changes during RUN SHALL have no effect.
REQ-022 start in the DONE cycle SHALL be accepted (back-to-back); done still pulses for the completed operation, and the next cycle is RUN.
REQ-023 All arithmetic SHALL be unsigned modulo 2^WIDTH; signedness is irrelevant for the low product bits.

Reset
REQ-024 rst=1 at an edge SHALL force state=IDLE, busy=0, done=0, result=0, acc=0, cnt=0, overriding start.
REQ-025 rst during RUN SHALL abort the operation with no done pulse; the result of the aborted operation is discarded.
REQ-026 After rst deasserts, the first start SHALL follow REQ-018 timing exactly.

Verification
REQ-027 srcA=7, srcB=6, start in cycle 0 -> busy in cycles 1-3, done in cycle 4, result=42.
REQ-028 srcA=0xFFFFFFFF, srcB=0xFFFFFFFF -> busy in cycles 1-32, done in cycle 33, result=0x00000001.
REQ-029 srcA=0x12345678, srcB=0 -> busy in cycle 1 only, done in cycle 2, result=0; srcB=1 gives done in cycle 2 with result=0x12345678.
REQ-030 srcA=3, srcB=0x80000000 with start re-asserted at cycle 5 using srcA=9, srcB=9 -> second start ignored, done in cycle 33, result=0x80000000.
REQ-031 srcA=5, srcB=5 with start also high in the DONE cycle (cycle 4) using srcA=2, srcB=3 -> first done in cycle 4 with result=25, second done in cycle 7 with result=6.
REQ-032 rst pulsed in cycle 10 of a 0xFFFF*0xFFFF operation -> no done, result=0, busy=0 from cycle 11; a new 7*6 request then completes per REQ-027.

Source files
------------

// File: rtl/sr_mul_seq.sv
// Radix-2 shift-add sequential multiplier returning the low WIDTH bits of srcA*srcB.
// Terminates early once the remaining multiplier bits are all zero.
module sr_mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] acc_r;
  logic [WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0] mplier_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] result_r;

  logic [WIDTH-1:0] acc_nxt_s;
  logic [WIDTH-1:0] mplier_nxt_s;
  logic             last_s;

  // One shift-add step; last_s flags that no further steps can change acc.
  always_comb begin
    acc_nxt_s    = acc_r;
    mplier_nxt_s = {1'b0, mplier_r[WIDTH-1:1]};
    last_s       = 1'b0;
    if (mplier_r[0]) begin
      acc_nxt_s = acc_r + mcand_r;
    end else begin
      acc_nxt_s = acc_r;
    end
    if ((mplier_nxt_s == {WIDTH{1'b0}}) || (cnt_r == CW'(WIDTH - 1))) begin
      last_s = 1'b1;
    end else begin
      last_s = 1'b0;
    end
  end

  // Sequencer state, datapath registers and the held result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      acc_r    <= {WIDTH{1'b0}};
      mcand_r  <= {WIDTH{1'b0}};
      mplier_r <= {WIDTH{1'b0}};
      cnt_r    <= {CW{1'b0}};
      result_r <= {WIDTH{1'b0}};
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (start) begin
            mcand_r  <= srcA;
            mplier_r <= srcB;
            acc_r    <= {WIDTH{1'b0}};
            cnt_r    <= {CW{1'b0}};
            state_r  <= RUN;
          end else begin
            state_r  <= IDLE;
          end
        end
        RUN: begin
          acc_r    <= acc_nxt_s;
          mcand_r  <= {mcand_r[WIDTH-2:0], 1'b0};
          mplier_r <= mplier_nxt_s;
          cnt_r    <= cnt_r + CW'(1);
          if (last_s) begin
            result_r <= acc_nxt_s;
            state_r  <= DONE;
          end else begin
            state_r  <= RUN;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign busy   = (state_r == RUN);
  assign done   = (state_r == DONE);
  assign result = result_r;

endmodule
